// File: rtl/sum_pkg.sv
// sum_pkg: shared widths and helpers for the adder / sum_buffer datapath.
package sum_pkg;

    localparam int DW    = 7;
    localparam int ACC_W = 10;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    function automatic int ptr_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sum_buffer.sv
// sum_buffer: first-word-fall-through FIFO for adder sums with a saturating
// running total of accepted samples and a sticky drop flag.
module sum_buffer
    import sum_pkg::ptr_w;
#(
    parameter int DEPTH = 4,
    parameter int DW    = sum_pkg::DW,
    parameter int ACC_W = sum_pkg::ACC_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DW-1:0]                in_data,
    input  logic                         out_ready,
    input  logic                         acc_clr,
    output logic                         out_valid,
    output logic [DW-1:0]                out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic [ACC_W-1:0]             acc
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DW-1:0]  mem [DEPTH];
    logic [PW-1:0]  head, tail;
    logic           push, pop;
    logic [ACC_W:0] sum;

    assign empty     = count == '0;
    assign full      = count == CW'(DEPTH);
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[head];
    assign pop       = out_valid && out_ready;
    // a full buffer still accepts when the head leaves in the same cycle
    assign push      = in_valid && (!full || pop);
    assign sum       = {1'b0, acc} + (ACC_W+1)'(in_data);

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) head <= head + PW'(1);
            if (push) tail <= tail + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (acc_clr) begin
                acc      <= push ? ACC_W'(in_data) : '0;
                overflow <= 1'b0;
            end else begin
                if (push) acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
                if (in_valid && !push) overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sum_buffer.sv
// tb_sum_buffer: scoreboard bench for sum_buffer with directed scenarios and
// randomized traffic against a queue-based reference model.
module tb_sum_buffer;

    localparam int DEPTH = 4;
    localparam int DW    = 7;
    localparam int ACC_W = 10;
    localparam int AMAX  = (1 << ACC_W) - 1;

    logic                       clk = 0;
    logic                       rst = 1;
    logic                       in_valid = 0;
    logic [DW-1:0]              in_data = 0;
    logic                       out_ready = 0;
    logic                       acc_clr = 0;
    logic                       out_valid;
    logic [DW-1:0]              out_data;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       full;
    logic                       empty;
    logic                       overflow;
    logic [ACC_W-1:0]           acc;

    sum_buffer #(.DEPTH(DEPTH), .DW(DW), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_data(out_data), .count(count), .full(full), .empty(empty),
        .overflow(overflow), .acc(acc)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int sb[$];
    int m_count = 0, m_acc = 0, m_ovf = 0;
    bit mon_en = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // issue one cycle of stimulus at posedge+1, then advance the model past the edge
    task automatic step(input bit iv, input int d, input bit ordy, input bit clr);
        bit p_pop, p_push;
        int n_count, n_acc, n_ovf;
        in_valid  = iv;
        in_data   = DW'(d);
        out_ready = ordy;
        acc_clr   = clr;
        p_pop  = ordy && m_count > 0;
        p_push = iv && (m_count < DEPTH || p_pop);
        n_count = m_count + int'(p_push) - int'(p_pop);
        if (p_push) sb.push_back(d);
        if (clr) begin
            n_acc = p_push ? d : 0;
            n_ovf = 0;
        end else begin
            n_acc = p_push ? ((m_acc + d > AMAX) ? AMAX : m_acc + d) : m_acc;
            n_ovf = (m_ovf != 0 || (iv && !p_push)) ? 1 : 0;
        end
        @(posedge clk);
        #1;
        m_count = n_count;
        m_acc   = n_acc;
        m_ovf   = n_ovf;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", int'(out_valid), int'(m_count != 0));
            check("count", int'(count), m_count);
            check("full", int'(full), int'(m_count == DEPTH));
            check("empty", int'(empty), int'(m_count == 0));
            check("acc", int'(acc), m_acc);
            check("overflow", int'(overflow), m_ovf);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("pop_on_empty_sb", 1, 0);
                else check("out_data", int'(out_data), sb.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_acc", int'(acc), 0);
        rst = 0;
        mon_en = 1;

        // fill, then drop a sample while full
        step(1, 5, 0, 0); step(1, 9, 0, 0); step(1, 30, 0, 0); step(1, 0, 0, 0);
        check("fill_full", int'(full), 1);
        check("fill_count", int'(count), 4);
        check("fill_head", int'(out_data), 5);
        check("fill_acc", int'(acc), 44);
        step(1, 12, 0, 0);
        check("drop_ovf", int'(overflow), 1);
        check("drop_count", int'(count), 4);
        check("drop_acc", int'(acc), 44);
        // push+pop while full reuses the freed slot
        step(1, 7, 1, 0);
        check("pp_count", int'(count), 4);
        check("pp_ovf", int'(overflow), 1);
        repeat (5) step(0, 0, 1, 0);
        check("drain_empty", int'(empty), 1);

        // saturation with continuous pop
        step(0, 0, 0, 1);
        repeat (9) step(1, 127, 1, 0);
        check("sat_acc", int'(acc), AMAX);

        // clear with a simultaneous push, contents preserved
        repeat (2) step(0, 0, 1, 0);
        step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 4, 0, 0);
        step(1, 5, 0, 0);
        step(1, 20, 1, 1);
        check("clr_acc", int'(acc), 20);
        check("clr_ovf", int'(overflow), 0);
        repeat (5) step(0, 0, 1, 0);

        // asynchronous reset with three entries stored
        step(1, 11, 0, 0); step(1, 22, 0, 0); step(1, 33, 0, 0);
        check("pre_rst_count", int'(count), 3);
        mon_en = 0;
        in_valid = 0;
        #2 rst = 1;
        #1;
        check("arst_empty", int'(empty), 1);
        check("arst_count", int'(count), 0);
        check("arst_acc", int'(acc), 0);
        check("arst_data", int'(out_data), 0);
        sb.delete();
        m_count = 0; m_acc = 0; m_ovf = 0;
        @(posedge clk);
        #1 rst = 0;
        mon_en = 1;
        step(1, 99, 0, 0);
        check("first_push_valid", int'(out_valid), 1);
        check("first_push_data", int'(out_data), 99);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 127)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        repeat (DEPTH + 1) step(0, 0, 1, 0);
        check("final_sb_empty", sb.size(), 0);

        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sum_buffer.md
SUM_BUFFER -- requirements
Module: sum_buffer

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of FIFO entries (power of two, >=2).
REQ-002 Parameter DW, default 7, meaning sum data width (matches adder result width).
REQ-003 Parameter ACC_W, default 10, meaning running-total width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream sum valid this cycle (no back-pressure to upstream).
REQ-007 in_data  input  DW  sum value from the adder stage.
REQ-008 out_ready  input  1  downstream consumer accepts head entry.
REQ-009 acc_clr  input  1  synchronous clear of acc and overflow.
REQ-010 out_valid  output  1  head entry present (= !empty).
REQ-011 out_data  output  DW  head entry, first-word-fall-through.
REQ-012 count  output  clog2(DEPTH+1)  number of stored entries.
REQ-013 full  output  1  count == DEPTH.
REQ-014 empty  output  1  count == 0.
REQ-015 overflow  output  1  sticky: a sample was dropped.
REQ-016 acc  output  ACC_W  saturating sum of all accepted samples.

Function
REQ-017 pop SHALL occur when out_valid && out_ready; head pointer advances, count decrements.
REQ-018 push SHALL occur when in_valid && (!full || pop); in_data written at tail, count increments.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; when full, the popped slot is reused the same cycle.
REQ-020 in_valid while full with no pop SHALL discard in_data, set overflow, leave count/acc unchanged.
REQ-021 Push into empty buffer SHALL present data on out_data with out_valid=1 the next cycle (latency 1); no same-cycle bypass.
REQ-022 out_ready while empty SHALL have no effect.
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-024 out_data SHALL hold the head entry stable while out_valid && !out_ready.
REQ-025 On push, acc SHALL become min(acc + in_data, 2^ACC_W-1), zero-extended addition, saturating at 1023 by default.
REQ-026 acc_clr SHALL take priority: acc <= (push ? in_data : 0), overflow <= 0; FIFO contents unaffected.
REQ-027 full, empty, count, out_valid SHALL be derived from registered state only.

Reset
REQ-028 rst high SHALL asynchronously force pointers, count, acc, overflow to 0; empty=1, full=0, out_valid=0, out_data=0.
REQ-029 Reset mid-operation SHALL discard all stored entries; storage array contents need not be cleared.
REQ-030 First push SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-031 Shared package sum_pkg SHALL hold DW, ACC_W, ACC_MAX and the pointer-width function; adder and sum_buffer both import it.
REQ-032 No sub-module; storage array, pointers and accumulator SHALL be inline in sum_buffer.

Verification
REQ-033 Fill: 4 pushes 5,9,30,0 with out_ready=0 -> full=1, count=4, out_data=5, acc=44.
REQ-034 Overflow: 5th push 12 while full, no pop -> overflow=1, count=4, acc=44; drain returns 5,9,30,0 in order.
REQ-035 Full with push+pop: push 7 with out_ready=1 -> count stays 4, 7 emerges after 0, overflow unchanged.
REQ-036 Saturation: 9 pushes of 127 with continuous pop -> acc=1023 after 9th, no wrap.
REQ-037 acc_clr with push 20 -> acc=20, overflow=0, stored entries still drain intact.
REQ-038 Async reset asserted mid-cycle with count=3 -> empty=1, count=0, acc=0 immediately, before next clk edge.
